// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU issue/writeback sequencer.
// Instruction layout: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2; LDI immediate in [8:0].
package alu_seq_pkg;

   localparam int DATA_W = 16;
   localparam int LDI_W  = 9;
   localparam int REG_N  = 8;
   localparam int REG_AW = 3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = LDI_W - 1;
   localparam int IMM_LSB = 0;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOTA = 4'b0101,
      OP_NOTB = 4'b0110,
      OP_SHL1 = 4'b0111,
      OP_SHR1 = 4'b1000,
      OP_LDI  = 4'b1001
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   // Opcodes up to SHR1 are executed by the external ALU.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= OP_SHR1;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction and result bus of the ALU sequencer.
// Handshake: a word transfers on a rising edge where instr_valid && instr_ready; res_valid is a one-cycle strobe.
interface alu_seq_if;
   import alu_seq_pkg::*;

   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic [REG_AW-1:0] res_rd;

   modport master (
      output instr_valid, instr_data,
      input  instr_ready, res_valid, res_data, res_rd
   );

   modport slave (
      input  instr_valid, instr_data,
      output instr_ready, res_valid, res_data, res_rd
   );
endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// 8 x DATA_W register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] i_ra1,
   input  logic [REG_AW-1:0] i_ra2,
   output logic [W-1:0]      o_rd1,
   output logic [W-1:0]      o_rd2,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wa,
   input  logic [W-1:0]      i_wd
);

   logic [W-1:0] r_mem [REG_N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
      end else if (i_we && (i_wa != '0)) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
   assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer around an external 16-bit combinational ALU.
// Optional macro FAST_ISSUE_EN: accept in WB (2-cycle ALU throughput) with a WB-to-source bypass.
module alu_op_sequencer
#(
   parameter int DATA_W = alu_seq_pkg::DATA_W,
   parameter int LDI_W  = alu_seq_pkg::LDI_W
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_seq_if.slave          bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              carry_flag,
   output logic              zero_flag,
   output logic              illegal_op,
   output logic [1:0]        dbg_state
);
   import alu_seq_pkg::*;

   state_e r_state, w_next_state;

   logic [3:0]        w_op;
   logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
   logic              w_is_alu, w_is_ldi, w_is_illegal;
   logic              w_ready, w_accept, w_we;
   logic [DATA_W-1:0] w_rf_rd1, w_rf_rd2, w_src1, w_src2, w_imm;

   logic [REG_AW-1:0] r_rd;
   logic [DATA_W-1:0] r_res;
   logic [DATA_W-1:0] r_alu_a, r_alu_b;
   logic [3:0]        r_alu_sel;
   logic              r_carry, r_zero, r_illegal;

   always_comb begin
      w_op         = bus.instr_data[OP_MSB:OP_LSB];
      w_rd         = bus.instr_data[RD_MSB:RD_LSB];
      w_rs1        = bus.instr_data[RS1_MSB:RS1_LSB];
      w_rs2        = bus.instr_data[RS2_MSB:RS2_LSB];
      w_imm        = {{(DATA_W-LDI_W){1'b0}}, bus.instr_data[LDI_W-1:0]};
      w_is_alu     = is_alu_op(w_op);
      w_is_ldi     = (w_op == OP_LDI);
      w_is_illegal = !w_is_alu && !w_is_ldi;
   end

   alu_seq_regfile #(.W(DATA_W)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ra1 (w_rs1),
      .i_ra2 (w_rs2),
      .o_rd1 (w_rf_rd1),
      .o_rd2 (w_rf_rd2),
      .i_we  (w_we),
      .i_wa  (r_rd),
      .i_wd  (r_res)
   );

`ifdef FAST_ISSUE_EN
   // The value being written this cycle is not yet visible in the regfile, so forward it.
   assign w_ready = (r_state == IDLE) || (r_state == WB);
   assign w_src1  = ((r_state == WB) && (r_rd != '0) && (w_rs1 == r_rd)) ? r_res : w_rf_rd1;
   assign w_src2  = ((r_state == WB) && (r_rd != '0) && (w_rs2 == r_rd)) ? r_res : w_rf_rd2;
`else
   assign w_ready = (r_state == IDLE);
   assign w_src1  = w_rf_rd1;
   assign w_src2  = w_rf_rd2;
`endif

   assign w_accept = bus.instr_valid && w_ready;
   assign w_we     = (r_state == WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, WB: begin
            w_next_state = IDLE;
            if (w_accept && w_is_alu)      w_next_state = EXEC;
            else if (w_accept && w_is_ldi) w_next_state = WB;
         end
         EXEC:    w_next_state = WB;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand/select registers change only when an ALU op is accepted, so the ALU inputs hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd      <= '0;
         r_res     <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_carry   <= 1'b0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_accept && w_is_illegal;
         if (w_accept && (w_is_alu || w_is_ldi)) r_rd <= w_rd;
         if (w_accept && w_is_alu) begin
            r_alu_a   <= w_src1;
            r_alu_b   <= w_src2;
            r_alu_sel <= w_op;
         end
         if (w_accept && w_is_ldi) r_res <= w_imm;
         if (r_state == EXEC) begin
            r_res  <= alu_out;
            r_zero <= (alu_out == '0);
            if (r_alu_sel == OP_ADD) r_carry <= alu_carry;
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.res_valid   = (r_state == WB);
   assign bus.res_data    = r_res;
   assign bus.res_rd      = r_rd;
   assign alu_a           = r_alu_a;
   assign alu_b           = r_alu_b;
   assign alu_sel         = r_alu_sel;
   assign carry_flag      = r_carry;
   assign zero_flag       = r_zero;
   assign illegal_op      = r_illegal;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instruction-level model with scoreboard, directed scenarios and random traffic.
// Works with or without FAST_ISSUE_EN defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int EXP_W = 53; // {cycle[31:0], carry, zero, rd[2:0], data[15:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry, carry_flag, zero_flag, illegal_op, noise;
  logic [1:0]  dbg_state;

  alu_seq_if bus ();

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk) noise <= 1'($urandom_range(0, 1));

  // ---------------- ALU (environment) ----------------
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, ~a};
      4'd6: return {1'b0, ~b};
      4'd7: return {1'b0, a << 1};
      4'd8: return {1'b0, a >> 1};
      default: return 17'd0;
    endcase
  endfunction

  logic [16:0] alu_full;
  always_comb begin
    alu_full  = alu_fn(alu_sel, alu_a, alu_b);
    alu_out   = alu_full[15:0];
    // Outside ADD the carry line is junk; the sequencer must ignore it.
    alu_carry = (alu_sel == 4'd0) ? alu_full[16] : noise;
  end

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit in_reset = 1'b1;
  logic [EXP_W-1:0] exp_q[$];
  int               ill_q[$];
  logic [15:0] m_rf [8];
  logic        m_carry, m_zero;
  logic [15:0] last_data;
  logic [2:0]  last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_carry = 1'b0;
    m_zero  = 1'b0;
    exp_q.delete();
    ill_q.delete();
  endfunction

  // Architectural effect of one accepted instruction; acc is the cycle count before the accepting edge.
  function automatic void model_issue(input logic [15:0] instr, input int acc);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b, res;
    logic [16:0] full;
    op = instr[15:12];
    rd = instr[11:9];
    a  = m_rf[instr[8:6]];
    b  = m_rf[instr[5:3]];
    if (op <= 4'd8) begin
      full = alu_fn(op, a, b);
      res  = full[15:0];
      m_zero = (res == 16'h0);
      if (op == 4'd0) m_carry = full[16];
      exp_q.push_back({32'(acc + 2), m_carry, m_zero, rd, res});
      if (rd != 3'd0) m_rf[rd] = res;
    end else if (op == 4'd9) begin
      res = {7'h0, instr[8:0]};
      exp_q.push_back({32'(acc + 1), m_carry, m_zero, rd, res});
      if (rd != 3'd0) m_rf[rd] = res;
    end else begin
      ill_q.push_back(acc + 1);
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!in_reset) begin
      while (exp_q.size() > 0 && int'(exp_q[0][52:21]) < cyc) begin
        check("res_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (bus.res_valid) begin
        if (exp_q.size() > 0 && int'(exp_q[0][52:21]) == cyc) begin
          e = exp_q.pop_front();
          check("res_data", bus.res_data, e[15:0]);
          check("res_rd", bus.res_rd, e[18:16]);
          check("zero_flag", zero_flag, e[19]);
          check("carry_flag", carry_flag, e[20]);
          last_data = bus.res_data;
          last_rd   = bus.res_rd;
        end else begin
          check("res_unexpected", 1, 0);
        end
      end
      while (ill_q.size() > 0 && ill_q[0] < cyc) begin
        check("illegal_missing", 0, 1);
        void'(ill_q.pop_front());
      end
      if (illegal_op) begin
        if (ill_q.size() > 0 && ill_q[0] == cyc) begin
          void'(ill_q.pop_front());
          check("illegal_pulse", 1, 1'(illegal_op));
        end else begin
          check("illegal_unexpected", 1, 0);
        end
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic issue(input logic [15:0] instr, output int acc);
    bit done = 1'b0;
    acc = -1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = instr;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.instr_ready) begin
        acc = cyc;
        model_issue(instr, cyc);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ill_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'b1001, rd, imm};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.instr_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_flags"}, {carry_flag, zero_flag, illegal_op}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0, a1, a2, a3, a4, gap;
    logic [15:0] w;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    // 1: LDI/LDI/ADD
    issue(ldi(3'd1, 9'd5), a0);
    issue(ldi(3'd2, 9'd3), a0);
    issue(enc(4'd0, 3'd3, 3'd1, 3'd2), a0);
    wait_idle();
    check("t1_data", last_data, 16'h0008);
    check("t1_rd", last_rd, 3);
    check("t1_flags", {carry_flag, zero_flag}, 2'b00);

    // 2: NOTA, carrying ADD, zero AND
    issue(ldi(3'd1, 9'h1FF), a0);
    issue(enc(4'd5, 3'd2, 3'd1, 3'd0), a0);
    wait_idle();
    check("t2_nota", last_data, 16'hFE00);
    issue(enc(4'd0, 3'd3, 3'd2, 3'd2), a0);
    wait_idle();
    check("t2_add", last_data, 16'hFC00);
    check("t2_carry", carry_flag, 1);
    issue(enc(4'd2, 3'd4, 3'd1, 3'd2), a0);
    wait_idle();
    check("t2_and", last_data, 16'h0000);
    check("t2_flags", {carry_flag, zero_flag}, 2'b11);

    // 3: r0 destination
    issue(ldi(3'd1, 9'd5), a0);
    issue(ldi(3'd2, 9'd3), a0);
    issue(enc(4'd0, 3'd0, 3'd1, 3'd2), a0);
    wait_idle();
    check("t3_data", last_data, 16'h0008);
    check("t3_rd", last_rd, 0);
    issue(enc(4'd3, 3'd5, 3'd0, 3'd0), a0);
    wait_idle();
    check("t3_or_r0", last_data, 16'h0000);

    // 4: illegal opcode
    issue({4'b1010, 12'h5A5}, a0);
    wait_idle();
    check("t4_flags", {carry_flag, zero_flag}, 2'b01);
    issue(ldi(3'd7, 9'h042), a0);
    wait_idle();
    check("t4_next", last_data, 16'h0042);

    // 5: held-valid ADD burst after LDI (bypass chain when fast issue is enabled)
    issue(ldi(3'd1, 9'd5), a0);
    issue(enc(4'd0, 3'd1, 3'd1, 3'd1), a1);
    issue(enc(4'd0, 3'd1, 3'd1, 3'd1), a2);
    issue(enc(4'd0, 3'd1, 3'd1, 3'd1), a3);
    issue(enc(4'd0, 3'd1, 3'd1, 3'd1), a4);
    wait_idle();
    check("t5_data", last_data, 16'h0050);
`ifdef FAST_ISSUE_EN
    gap = 2;
`else
    gap = 3;
`endif
    check("t5_spacing12", a2 - a1, 64'(gap));
    check("t5_spacing23", a3 - a2, 64'(gap));
    check("t5_spacing34", a4 - a3, 64'(gap));

    // 6: reset during EXEC of SUB r6
    issue(enc(4'd1, 3'd6, 3'd1, 3'd2), a0);
    #2 rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    check("t6_ready", bus.instr_ready, 1);
    issue(enc(4'd3, 3'd7, 3'd6, 3'd6), a0);
    wait_idle();
    check("t6_r6", last_data, 16'h0000);
    check("t6_rd", last_rd, 7);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    w = ldi(3'($urandom_range(0, 7)), 9'($urandom));
        2:       w = {4'($urandom_range(10, 15)), 12'($urandom)};
        default: w = {4'($urandom_range(0, 8)), 12'($urandom)};
      endcase
      issue(w, a0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_idle();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_ill_empty", ill_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
